// File: rtl/xf100_mtimer_pkg.sv
// Shared constants for the xf100 machine timer: register offsets, CTRL field
// positions, reset values and a helper that packs the CTRL read-back word.
package xf100_mtimer_pkg;

    localparam int XF100_MTIMER_AW = 3;

    typedef logic [2:0] reg_off_t;

    localparam reg_off_t XF100_MTIMER_MTIME_LO    = 3'd0;
    localparam reg_off_t XF100_MTIMER_MTIME_HI    = 3'd1;
    localparam reg_off_t XF100_MTIMER_MTIMECMP_LO = 3'd2;
    localparam reg_off_t XF100_MTIMER_MTIMECMP_HI = 3'd3;
    localparam reg_off_t XF100_MTIMER_CTRL        = 3'd4;
    localparam reg_off_t XF100_MTIMER_PRESC       = 3'd5;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_DIV_LSB = 8;
    localparam int CTRL_DIV_MSB = 15;
    localparam int DIV_W        = CTRL_DIV_MSB - CTRL_DIV_LSB + 1;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [31:0] ctrl_word(input logic [DIV_W-1:0] div, input logic en);
        logic [31:0] w;
        w = '0;
        w[CTRL_DIV_MSB:CTRL_DIV_LSB] = div;
        w[CTRL_EN_BIT] = en;
        return w;
    endfunction

endpackage

// File: rtl/xf100_mtimer_bwreg.sv
// 32-bit register with per-byte write enables and a full-word load port.
// A byte write takes priority over the load for that lane only.
module xf100_mtimer_bwreg #(
    parameter logic [31:0] RST_VAL = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  be,
    input  logic [31:0] wdat,
    input  logic        ld,
    input  logic [31:0] ld_dat,
    output logic [31:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_reg <= RST_VAL[8*gi +: 8];
                end else if (be[gi]) begin
                    lane_reg <= wdat[8*gi +: 8];
                end else if (ld) begin
                    lane_reg <= ld_dat[8*gi +: 8];
                end
            end

            assign q[8*gi +: 8] = lane_reg;
        end
    endgenerate

endmodule

// File: rtl/xf100_mtimer.sv
// Memory-mapped machine timer: prescaled 64-bit mtime, 64-bit mtimecmp, CTRL,
// registered read port and a level interrupt when mtime >= mtimecmp.
module xf100_mtimer
    import xf100_mtimer_pkg::*;
#(
    parameter int AW = XF100_MTIMER_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tmr_i_cs,
    input  logic          tmr_i_wen,
    input  logic [3:0]    tmr_i_mask,
    input  logic [AW-1:0] tmr_i_addr,
    input  logic [7:0]    tmr_i_wdat0,
    input  logic [7:0]    tmr_i_wdat1,
    input  logic [7:0]    tmr_i_wdat2,
    input  logic [7:0]    tmr_i_wdat3,
    output logic [7:0]    tmr_o_rdat0,
    output logic [7:0]    tmr_o_rdat1,
    output logic [7:0]    tmr_o_rdat2,
    output logic [7:0]    tmr_o_rdat3,
    output logic          tmr_o_irq
);

    logic [31:0]      wdat;
    reg_off_t         off;
    logic             wr;
    logic             rd;
    logic [3:0]       be_word [4];
    logic [3:0]       be_ctrl;
    logic [31:0]      word_q  [4];
    logic [31:0]      ld_dat  [4];
    logic [3:0]       ld_vec;
    logic [63:0]      mtime;
    logic [63:0]      mtimecmp;
    logic [63:0]      mtime_inc;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_next;
    logic             en_reg;
    logic             en_next;
    logic [DIV_W-1:0] presc_reg;
    logic [DIV_W-1:0] presc_next;
    logic             ctrl_abort;
    logic             tick;
    logic             mtime_wr;
    logic             mtime_ld;
    logic [31:0]      rdat_reg;
    logic [31:0]      rdat_next;
    logic             irq_reg;

    assign wdat = {tmr_i_wdat3, tmr_i_wdat2, tmr_i_wdat1, tmr_i_wdat0};
    assign off  = tmr_i_addr[2:0];
    assign wr   = tmr_i_cs & tmr_i_wen;
    assign rd   = tmr_i_cs & ~tmr_i_wen;

    assign be_ctrl = (wr && off == XF100_MTIMER_CTRL) ? tmr_i_mask : 4'b0000;

    // A write to either mtime word cancels the whole 64-bit increment.
    assign mtime_wr  = wr && (off == XF100_MTIMER_MTIME_LO || off == XF100_MTIMER_MTIME_HI);
    assign mtime     = {word_q[1], word_q[0]};
    assign mtimecmp  = {word_q[3], word_q[2]};
    assign mtime_inc = mtime + 64'd1;
    assign mtime_ld  = tick & ~mtime_wr;

    assign ld_vec    = {1'b0, 1'b0, mtime_ld, mtime_ld};
    assign ld_dat[0] = mtime_inc[31:0];
    assign ld_dat[1] = mtime_inc[63:32];
    assign ld_dat[2] = 32'h0;
    assign ld_dat[3] = 32'h0;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_word
            assign be_word[gi] = (wr && off == reg_off_t'(gi)) ? tmr_i_mask : 4'b0000;

            xf100_mtimer_bwreg #(
                .RST_VAL((gi == 2) ? MTIMECMP_RST[31:0] :
                         (gi == 3) ? MTIMECMP_RST[63:32] : 32'h0)
            ) u_word (
                .clk    (clk),
                .rst_n  (rst_n),
                .be     (be_word[gi]),
                .wdat   (wdat),
                .ld     (ld_vec[gi]),
                .ld_dat (ld_dat[gi]),
                .q      (word_q[gi])
            );
        end
    endgenerate

    // Prescaler: presc never exceeds div_reg, so only a CTRL write lowering DIV
    // below the running count needs the abort path.
    always_comb begin
        div_next   = be_ctrl[1] ? wdat[CTRL_DIV_MSB:CTRL_DIV_LSB] : div_reg;
        en_next    = be_ctrl[0] ? wdat[CTRL_EN_BIT] : en_reg;
        ctrl_abort = (div_next < presc_reg);
        tick       = en_reg & (presc_reg == div_reg) & ~ctrl_abort;
        presc_next = presc_reg;
        if (ctrl_abort) begin
            presc_next = '0;
        end else if (en_reg) begin
            presc_next = tick ? '0 : presc_reg + 1'b1;
        end
    end

    always_comb begin
        rdat_next = 32'h0;
        case (off)
            XF100_MTIMER_MTIME_LO:    rdat_next = word_q[0];
            XF100_MTIMER_MTIME_HI:    rdat_next = word_q[1];
            XF100_MTIMER_MTIMECMP_LO: rdat_next = word_q[2];
            XF100_MTIMER_MTIMECMP_HI: rdat_next = word_q[3];
            XF100_MTIMER_CTRL:        rdat_next = ctrl_word(div_reg, en_reg);
            XF100_MTIMER_PRESC:       rdat_next = {{(32-DIV_W){1'b0}}, presc_reg};
            default:                  rdat_next = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg   <= '0;
            en_reg    <= 1'b0;
            presc_reg <= '0;
            rdat_reg  <= 32'h0;
            irq_reg   <= 1'b0;
        end else begin
            div_reg   <= div_next;
            en_reg    <= en_next;
            presc_reg <= presc_next;
            irq_reg   <= (mtime >= mtimecmp);
            if (rd) begin
                rdat_reg <= rdat_next;
            end
        end
    end

    assign tmr_o_rdat0 = rdat_reg[7:0];
    assign tmr_o_rdat1 = rdat_reg[15:8];
    assign tmr_o_rdat2 = rdat_reg[23:16];
    assign tmr_o_rdat3 = rdat_reg[31:24];
    assign tmr_o_irq   = irq_reg;

endmodule

// File: tb/tb_xf100_mtimer.sv
// Directed bench for xf100_mtimer: reads push expected words into a scoreboard,
// a monitor pops and compares one cycle after each read is accepted.
module tb_xf100_mtimer;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs    = 1'b0;
    logic       wen   = 1'b0;
    logic [3:0] mask  = 4'b0;
    logic [2:0] addr  = 3'd0;
    logic [7:0] wdat0 = 8'h0;
    logic [7:0] wdat1 = 8'h0;
    logic [7:0] wdat2 = 8'h0;
    logic [7:0] wdat3 = 8'h0;
    logic [7:0] rdat0, rdat1, rdat2, rdat3;
    logic       irq;
    logic [31:0] rdat_word;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q  [$];
    logic [2:0]  addr_q [$];

    assign rdat_word = {rdat3, rdat2, rdat1, rdat0};

    always #5 clk = ~clk;

    xf100_mtimer #(.AW(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tmr_i_cs    (cs),
        .tmr_i_wen   (wen),
        .tmr_i_mask  (mask),
        .tmr_i_addr  (addr),
        .tmr_i_wdat0 (wdat0),
        .tmr_i_wdat1 (wdat1),
        .tmr_i_wdat2 (wdat2),
        .tmr_i_wdat3 (wdat3),
        .tmr_o_rdat0 (rdat0),
        .tmr_o_rdat1 (rdat1),
        .tmr_o_rdat2 (rdat2),
        .tmr_o_rdat3 (rdat3),
        .tmr_o_irq   (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end else begin
            $display("ok   %s: %08h", name, act);
        end
    endtask

    // Called just after a negedge; the access lands on the following posedge.
    task automatic wr_word(input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
        cs = 1'b1; wen = 1'b1; addr = a; mask = m;
        {wdat3, wdat2, wdat1, wdat0} = d;
        $display("write off=%0d data=%08h mask=%04b", a, d, m);
        @(negedge clk);
        cs = 1'b0; wen = 1'b0; mask = 4'b0;
    endtask

    task automatic rd_word(input logic [2:0] a, input logic [31:0] exp);
        cs = 1'b1; wen = 1'b0; addr = a; mask = 4'b0;
        exp_q.push_back(exp);
        addr_q.push_back(a);
        @(negedge clk);
        cs = 1'b0;
    endtask

    // Monitor: a read accepted at a posedge is compared at the next negedge.
    initial begin
        forever begin
            @(posedge clk);
            if (cs && !wen) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL read_unexpected: got %08h expected no read", rdat_word);
                end else begin
                    check($sformatf("read off=%0d", addr_q.pop_front()), rdat_word, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset rdat", rdat_word, 32'h0);
        check("reset irq", {31'b0, irq}, 32'h0);

        // Reset values of every offset
        rd_word(3'd0, 32'h0000_0000);
        rd_word(3'd1, 32'h0000_0000);
        rd_word(3'd2, 32'hFFFF_FFFF);
        rd_word(3'd3, 32'hFFFF_FFFF);
        rd_word(3'd4, 32'h0000_0000);
        rd_word(3'd5, 32'h0000_0000);
        rd_word(3'd6, 32'h0000_0000);
        rd_word(3'd7, 32'h0000_0000);

        // Byte lanes, RAZ/WI offsets, read-only PRESC, CTRL reserved bits
        wr_word(3'd2, 32'hAABB_CCDD, 4'b0101);
        rd_word(3'd2, 32'hFFBB_FFDD);
        rd_word(3'd6, 32'h0000_0000);
        wr_word(3'd6, 32'hFFFF_FFFF, 4'b1111);
        rd_word(3'd6, 32'h0000_0000);
        wr_word(3'd5, 32'h1234_5678, 4'b1111);
        rd_word(3'd5, 32'h0000_0000);
        wr_word(3'd4, 32'hFFFF_FF00, 4'b1111);
        rd_word(3'd4, 32'h0000_FF00);
        rd_word(3'd2, 32'hFFBB_FFDD);
        wr_word(3'd7, 32'h0000_0000, 4'b1111);
        repeat (2) @(negedge clk);
        check("rdat hold", rdat_word, 32'hFFBB_FFDD);

        // Prescale DIV=3: 41 enabled edges -> 10 ticks, presc left at 1
        wr_word(3'd4, 32'h0000_0301, 4'b1111);
        repeat (40) @(negedge clk);
        wr_word(3'd4, 32'h0000_0000, 4'b0001);
        rd_word(3'd0, 32'd10);
        rd_word(3'd5, 32'd1);
        rd_word(3'd4, 32'h0000_0300);
        repeat (20) @(negedge clk);
        rd_word(3'd0, 32'd10);

        // Carry LO->HI and full 64-bit wrap, each with exactly one tick
        wr_word(3'd0, 32'hFFFF_FFFF, 4'b1111);
        wr_word(3'd1, 32'h0000_0000, 4'b1111);
        wr_word(3'd4, 32'h0000_0001, 4'b1111);
        wr_word(3'd4, 32'h0000_0000, 4'b0001);
        rd_word(3'd1, 32'h0000_0001);
        rd_word(3'd0, 32'h0000_0000);
        wr_word(3'd0, 32'hFFFF_FFFF, 4'b1111);
        wr_word(3'd1, 32'hFFFF_FFFF, 4'b1111);
        wr_word(3'd4, 32'h0000_0001, 4'b1111);
        wr_word(3'd4, 32'h0000_0000, 4'b0001);
        rd_word(3'd0, 32'h0000_0000);
        rd_word(3'd1, 32'h0000_0000);

        // Write/tick collision: dropped tick must not carry into HI
        wr_word(3'd0, 32'hFFFF_FFFF, 4'b1111);
        wr_word(3'd1, 32'h0000_0005, 4'b1111);
        wr_word(3'd4, 32'h0000_0001, 4'b1111);
        wr_word(3'd0, 32'h0000_0100, 4'b1111);
        rd_word(3'd0, 32'h0000_0100);
        rd_word(3'd1, 32'h0000_0005);
        wr_word(3'd4, 32'h0000_0000, 4'b0001);
        rd_word(3'd0, 32'h0000_0103);
        rd_word(3'd1, 32'h0000_0005);

        // Interrupt: cmp = 20, DIV=0; irq rises on the edge after mtime hits 20
        wr_word(3'd0, 32'h0, 4'b1111);
        wr_word(3'd1, 32'h0, 4'b1111);
        wr_word(3'd2, 32'd20, 4'b1111);
        wr_word(3'd3, 32'h0, 4'b1111);
        check("irq before enable", {31'b0, irq}, 32'h0);
        wr_word(3'd4, 32'h0000_0001, 4'b1111);
        repeat (19) @(negedge clk);
        @(negedge clk);
        check("irq at mtime=20", {31'b0, irq}, 32'h0);
        @(negedge clk);
        check("irq one cycle later", {31'b0, irq}, 32'h1);
        wr_word(3'd3, 32'h0000_0001, 4'b1111);
        check("irq on cmp write edge", {31'b0, irq}, 32'h1);
        @(negedge clk);
        check("irq after cmp raised", {31'b0, irq}, 32'h0);
        wr_word(3'd4, 32'h0000_0000, 4'b0001);
        rd_word(3'd0, 32'd24);
        wr_word(3'd3, 32'h0000_0000, 4'b1111);
        repeat (2) @(negedge clk);
        check("irq with timer frozen", {31'b0, irq}, 32'h1);
        rd_word(3'd2, 32'd20);
        @(negedge clk);

        // Asynchronous reset away from a clock edge
        #2 rst_n = 1'b0;
        #1;
        check("async reset rdat", rdat_word, 32'h0);
        check("async reset irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd_word(3'd0, 32'h0000_0000);
        rd_word(3'd3, 32'hFFFF_FFFF);
        rd_word(3'd4, 32'h0000_0000);
        repeat (2) @(negedge clk);
        check("irq after reset", {31'b0, irq}, 32'h0);

        repeat (2) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
